// File: rtl/servile_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single memory slave.
// Optional slave-wait watchdog enabled by defining SERVILE_ARB_TIMEOUT_EN.
module servile_arbiter #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_m0_adr,
    input  logic [31:0] i_wb_m0_dat,
    input  logic [3:0]  i_wb_m0_sel,
    input  logic        i_wb_m0_we,
    input  logic        i_wb_m0_stb,
    output logic [31:0] o_wb_m0_rdt,
    output logic        o_wb_m0_ack,
    input  logic [31:0] i_wb_m1_adr,
    input  logic [31:0] i_wb_m1_dat,
    input  logic [3:0]  i_wb_m1_sel,
    input  logic        i_wb_m1_we,
    input  logic        i_wb_m1_stb,
    output logic [31:0] o_wb_m1_rdt,
    output logic        o_wb_m1_ack,
    output logic [31:0] o_wb_mem_adr,
    output logic [31:0] o_wb_mem_dat,
    output logic [3:0]  o_wb_mem_sel,
    output logic        o_wb_mem_we,
    output logic        o_wb_mem_stb,
    input  logic [31:0] i_wb_mem_rdt,
`ifdef SERVILE_ARB_TIMEOUT_EN
    output logic        o_timeout,
`endif
    input  logic        i_wb_mem_ack
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        gnt_stb_s;
    logic        ack_s;
    logic [31:0] rdt_s;

`ifdef SERVILE_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    assign o_timeout = timeout_q;
`else
    logic        unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_L;
`endif

    // Arbitration, datapath steering and next-state; reset gates every handshake output.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        ack_s        = 1'b0;
        rdt_s        = 32'h0000_0000;
        gnt_stb_s    = grant_q ? i_wb_m1_stb : i_wb_m0_stb;
        o_wb_mem_adr = i_wb_m0_adr;
        o_wb_mem_dat = i_wb_m0_dat;
        o_wb_mem_sel = i_wb_m0_sel;
        o_wb_mem_we  = i_wb_m0_we;
        o_wb_mem_stb = 1'b0;
`ifdef SERVILE_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
`endif
        if (i_rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_wb_m0_stb && i_wb_m1_stb) begin
                        state_d = BUSY;
                        grant_d = ~last_q;
                    end else if (i_wb_m0_stb || i_wb_m1_stb) begin
                        state_d = BUSY;
                        grant_d = i_wb_m1_stb;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    if (grant_q) begin
                        o_wb_mem_adr = i_wb_m1_adr;
                        o_wb_mem_dat = i_wb_m1_dat;
                        o_wb_mem_sel = i_wb_m1_sel;
                        o_wb_mem_we  = i_wb_m1_we;
                    end else begin
                        o_wb_mem_adr = i_wb_m0_adr;
                        o_wb_mem_dat = i_wb_m0_dat;
                        o_wb_mem_sel = i_wb_m0_sel;
                        o_wb_mem_we  = i_wb_m0_we;
                    end
                    o_wb_mem_stb = gnt_stb_s;
                    rdt_s        = i_wb_mem_rdt;
                    // An aborted request returns to IDLE without touching the round-robin pointer.
                    if (!gnt_stb_s) begin
                        state_d = IDLE;
                    end else if (i_wb_mem_ack) begin
                        ack_s   = 1'b1;
                        state_d = IDLE;
                        last_d  = grant_q;
`ifdef SERVILE_ARB_TIMEOUT_EN
                    end else if ((cnt_q + 16'd1) == TIMEOUT_L) begin
                        o_wb_mem_stb = 1'b0;
                        ack_s        = 1'b1;
                        rdt_s        = 32'hFFFF_FFFF;
                        timeout_d    = 1'b1;
                        state_d      = IDLE;
                        last_d       = grant_q;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
`else
                    end else begin
                        state_d = BUSY;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
`ifdef SERVILE_ARB_TIMEOUT_EN
        if (state_d == IDLE) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_d;
        end
`endif
        o_wb_m0_ack = ack_s & ~grant_q;
        o_wb_m1_ack = ack_s & grant_q;
        o_wb_m0_rdt = grant_q ? 32'h0000_0000 : rdt_s;
        o_wb_m1_rdt = grant_q ? rdt_s : 32'h0000_0000;
    end

    // State, grant and round-robin pointer registers; m0 wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
`ifdef SERVILE_ARB_TIMEOUT_EN
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
`ifdef SERVILE_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_servile_arbiter.sv
// Directed, table-driven bench for servile_arbiter; the timeout sequence runs
// only when SERVILE_ARB_TIMEOUT_EN is defined.
module tb_servile_arbiter;

    localparam logic [31:0] ADR0 = 32'h0000_0100;
    localparam logic [31:0] ADR1 = 32'h0000_0040;
    localparam logic [31:0] DV   = 32'h1234_5678;
    localparam logic [31:0] EV   = 32'hA5A5_0001;
    localparam logic [31:0] ZV   = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_wb_m0_adr, i_wb_m0_dat, i_wb_m1_adr, i_wb_m1_dat, i_wb_mem_rdt;
    logic [3:0]  i_wb_m0_sel, i_wb_m1_sel;
    logic        i_wb_m0_we, i_wb_m0_stb, i_wb_m1_we, i_wb_m1_stb, i_wb_mem_ack;
    logic [31:0] o_wb_m0_rdt, o_wb_m1_rdt, o_wb_mem_adr, o_wb_mem_dat;
    logic [3:0]  o_wb_mem_sel;
    logic        o_wb_m0_ack, o_wb_m1_ack, o_wb_mem_we, o_wb_mem_stb;
`ifdef SERVILE_ARB_TIMEOUT_EN
    logic        o_timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    servile_arbiter #(.TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wb_m0_adr  (i_wb_m0_adr),
        .i_wb_m0_dat  (i_wb_m0_dat),
        .i_wb_m0_sel  (i_wb_m0_sel),
        .i_wb_m0_we   (i_wb_m0_we),
        .i_wb_m0_stb  (i_wb_m0_stb),
        .o_wb_m0_rdt  (o_wb_m0_rdt),
        .o_wb_m0_ack  (o_wb_m0_ack),
        .i_wb_m1_adr  (i_wb_m1_adr),
        .i_wb_m1_dat  (i_wb_m1_dat),
        .i_wb_m1_sel  (i_wb_m1_sel),
        .i_wb_m1_we   (i_wb_m1_we),
        .i_wb_m1_stb  (i_wb_m1_stb),
        .o_wb_m1_rdt  (o_wb_m1_rdt),
        .o_wb_m1_ack  (o_wb_m1_ack),
        .o_wb_mem_adr (o_wb_mem_adr),
        .o_wb_mem_dat (o_wb_mem_dat),
        .o_wb_mem_sel (o_wb_mem_sel),
        .o_wb_mem_we  (o_wb_mem_we),
        .o_wb_mem_stb (o_wb_mem_stb),
        .i_wb_mem_rdt (i_wb_mem_rdt),
`ifdef SERVILE_ARB_TIMEOUT_EN
        .o_timeout    (o_timeout),
`endif
        .i_wb_mem_ack (i_wb_mem_ack)
    );

    typedef struct {
        logic        rst;
        logic        s0;
        logic        s1;
        logic        ack;
        logic [31:0] rdt;
        logic        e_stb;
        logic        e_a0;
        logic        e_a1;
        logic [31:0] e_r0;
        logic [31:0] e_r1;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic s0, input logic s1, input logic ack,
                       input logic [31:0] rdt, input logic e_stb, input logic e_a0,
                       input logic e_a1, input logic [31:0] e_r0, input logic [31:0] e_r1,
                       input logic [31:0] e_adr);
        vec_t v;
        v.rst = rst; v.s0 = s0; v.s1 = s1; v.ack = ack; v.rdt = rdt;
        v.e_stb = e_stb; v.e_a0 = e_a0; v.e_a1 = e_a1;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_adr = e_adr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic s0, input logic s1, input logic ack,
                         input logic [31:0] rdt);
        i_rst        = rst;
        i_wb_m0_stb  = s0;
        i_wb_m1_stb  = s1;
        i_wb_mem_ack = ack;
        i_wb_mem_rdt = rdt;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int last_ack_cyc;
        logic exp_g;

        i_wb_m0_adr = ADR0; i_wb_m0_dat = 32'hDEAD_0000; i_wb_m0_sel = 4'hF; i_wb_m0_we = 1'b1;
        i_wb_m1_adr = ADR1; i_wb_m1_dat = 32'hBEEF_0001; i_wb_m1_sel = 4'h3; i_wb_m1_we = 1'b0;

        //   rst   s0    s1    ack   rdt   stb   a0    a1    r0  r1  adr
        add(1'b1, 1'b1, 1'b1, 1'b1, DV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // in reset
        add(1'b0, 1'b0, 1'b0, 1'b0, DV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // cycle after reset
        add(1'b0, 1'b1, 1'b1, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // tie, arbitrate
        add(1'b0, 1'b1, 1'b1, 1'b0, ZV, 1'b1, 1'b0, 1'b0, ZV, ZV, ADR0); // m0 granted
        add(1'b0, 1'b1, 1'b1, 1'b1, DV, 1'b1, 1'b1, 1'b0, DV, ZV, ADR0); // m0 acked
        add(1'b0, 1'b0, 1'b1, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // idle gap
        add(1'b0, 1'b0, 1'b1, 1'b0, DV, 1'b1, 1'b0, 1'b0, ZV, DV, ADR1); // m1 wait 1
        add(1'b0, 1'b0, 1'b1, 1'b0, ZV, 1'b1, 1'b0, 1'b0, ZV, ZV, ADR1); // m1 wait 2
        add(1'b0, 1'b0, 1'b1, 1'b0, ZV, 1'b1, 1'b0, 1'b0, ZV, ZV, ADR1); // m1 wait 3
        add(1'b0, 1'b0, 1'b1, 1'b1, DV, 1'b1, 1'b0, 1'b1, ZV, DV, ADR1); // m1 acked
        add(1'b0, 1'b0, 1'b0, 1'b1, DV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // stray ack in idle
        add(1'b0, 1'b1, 1'b0, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // m0 request
        add(1'b0, 1'b0, 1'b0, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // m0 aborts
        add(1'b0, 1'b1, 1'b1, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // tie, pointer still m1
        add(1'b0, 1'b1, 1'b1, 1'b0, ZV, 1'b1, 1'b0, 1'b0, ZV, ZV, ADR0); // m0 granted
        add(1'b0, 1'b1, 1'b1, 1'b1, EV, 1'b1, 1'b1, 1'b0, EV, ZV, ADR0); // m0 acked
        add(1'b0, 1'b0, 1'b1, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // m1 request
        add(1'b0, 1'b0, 1'b1, 1'b0, ZV, 1'b1, 1'b0, 1'b0, ZV, ZV, ADR1); // m1 busy
        add(1'b1, 1'b0, 1'b1, 1'b1, DV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // reset mid-busy
        add(1'b0, 1'b1, 1'b1, 1'b0, ZV, 1'b0, 1'b0, 1'b0, ZV, ZV, ADR0); // idle, tie
        add(1'b0, 1'b1, 1'b1, 1'b0, ZV, 1'b1, 1'b0, 1'b0, ZV, ZV, ADR0); // m0 wins after reset
        add(1'b0, 1'b1, 1'b1, 1'b1, EV, 1'b1, 1'b1, 1'b0, EV, ZV, ADR0); // m0 acked

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].s0, vecs[i].s1, vecs[i].ack, vecs[i].rdt);
            @(negedge i_clk);
            check($sformatf("v%0d_mem_stb", i), {31'd0, o_wb_mem_stb}, {31'd0, vecs[i].e_stb});
            check($sformatf("v%0d_m0_ack", i), {31'd0, o_wb_m0_ack}, {31'd0, vecs[i].e_a0});
            check($sformatf("v%0d_m1_ack", i), {31'd0, o_wb_m1_ack}, {31'd0, vecs[i].e_a1});
            check($sformatf("v%0d_m0_rdt", i), o_wb_m0_rdt, vecs[i].e_r0);
            check($sformatf("v%0d_m1_rdt", i), o_wb_m1_rdt, vecs[i].e_r1);
            check($sformatf("v%0d_mem_adr", i), o_wb_mem_adr, vecs[i].e_adr);
            check($sformatf("v%0d_mem_we", i), {31'd0, o_wb_mem_we},
                  {31'd0, (vecs[i].e_adr == ADR0)});
            next_cycle();
        end

        // Back-to-back contention: last winner is m0, so m1 goes first and grants alternate.
        exp_g = 1'b1;
        last_ack_cyc = 0;
        for (int t = 0; t < 8; t++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100 + 32'(t));
            @(negedge i_clk);
            check($sformatf("rr%0d_idle_stb", t), {31'd0, o_wb_mem_stb}, 32'd0);
            check($sformatf("rr%0d_idle_acks", t), {30'd0, o_wb_m1_ack, o_wb_m0_ack}, 32'd0);
            next_cycle();
            @(negedge i_clk);
            check($sformatf("rr%0d_acks", t), {30'd0, o_wb_m1_ack, o_wb_m0_ack},
                  exp_g ? 32'd2 : 32'd1);
            check($sformatf("rr%0d_adr", t), o_wb_mem_adr, exp_g ? ADR1 : ADR0);
            check($sformatf("rr%0d_rdt", t), exp_g ? o_wb_m1_rdt : o_wb_m0_rdt,
                  32'h0000_0100 + 32'(t));
            if (t > 0) begin
                check($sformatf("rr%0d_spacing", t), 32'(2 * t + 1 - last_ack_cyc), 32'd2);
            end else begin
                last_ack_cyc = 1;
            end
            last_ack_cyc = 2 * t + 1;
            exp_g = ~exp_g;
            next_cycle();
        end

`ifdef SERVILE_ARB_TIMEOUT_EN
        // Memory never acks: forced error ack on the fourth wait cycle, sticky flag afterwards.
        drive(1'b0, 1'b1, 1'b0, 1'b0, ZV);
        @(negedge i_clk);
        check("to_flag_clear", {31'd0, o_timeout}, 32'd0);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            @(negedge i_clk);
            check($sformatf("to_wait%0d_stb", k), {31'd0, o_wb_mem_stb}, (k == 4) ? 32'd0 : 32'd1);
            check($sformatf("to_wait%0d_ack", k), {31'd0, o_wb_m0_ack}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) begin
                check("to_rdt", o_wb_m0_rdt, 32'hFFFF_FFFF);
            end else begin
                check($sformatf("to_wait%0d_flag", k), {31'd0, o_timeout}, 32'd0);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, ZV);
        @(negedge i_clk);
        check("to_flag_set", {31'd0, o_timeout}, 32'd1);
        next_cycle();
        @(negedge i_clk);
        check("to_flag_sticky", {31'd0, o_timeout}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, ZV);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, ZV);
        @(negedge i_clk);
        check("to_flag_reset", {31'd0, o_timeout}, 32'd0);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servile_arbiter.md
SERVILE_ARBITER -- requirements
Module: servile_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning slave-wait cycles before forced termination; legal range 1..65535; used only with SERVILE_ARB_TIMEOUT_EN.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports i_wb_m0_adr/i_wb_m0_dat  input  32 each, i_wb_m0_sel  input  4, i_wb_m0_we/i_wb_m0_stb  input  1 each; master 0 (CPU) request.
REQ-005 SHALL have ports o_wb_m0_rdt  output  32, o_wb_m0_ack  output  1; master 0 response.
REQ-006 SHALL have ports i_wb_m1_adr/dat (32), i_wb_m1_sel (4), i_wb_m1_we/stb (1), o_wb_m1_rdt (32), o_wb_m1_ack (1), same directions as m0; master 1 (debug/DMA).
REQ-007 SHALL have ports o_wb_mem_adr/dat (32), o_wb_mem_sel (4), o_wb_mem_we/stb (1) outputs, i_wb_mem_rdt (32), i_wb_mem_ack (1) inputs; shared memory slave.
REQ-008 SHALL have port o_timeout  output  1  sticky flag, present only with SERVILE_ARB_TIMEOUT_EN.

Function
REQ-009 SHALL implement states IDLE and BUSY plus registered grant (0/1) and last-winner pointer.
REQ-010 In IDLE with exactly one stb high, SHALL enter BUSY next cycle granting that master.
REQ-011 In IDLE with both stb high, SHALL grant the master that is not the last winner (round-robin).
REQ-012 In IDLE, o_wb_mem_stb SHALL be 0; arbitration costs exactly one cycle.
REQ-013 In BUSY, o_wb_mem_adr/dat/sel/we SHALL mirror the granted master; o_wb_mem_stb SHALL equal granted stb.
REQ-014 In BUSY, granted master's ack/rdt SHALL equal i_wb_mem_ack/i_wb_mem_rdt combinationally; zero latency added.
REQ-015 Non-granted master's ack SHALL be 0 and rdt 32'h0 at all times; in IDLE both acks 0, both rdt 0.
REQ-016 On i_wb_mem_ack in BUSY, SHALL return to IDLE next cycle and set last winner to the granted master.
REQ-017 If granted stb drops before ack (abort), SHALL return to IDLE next cycle without ack and without updating last winner.
REQ-018 i_wb_mem_ack while IDLE SHALL be ignored (no master acked).
REQ-019 Requests from the non-granted master during BUSY SHALL be held off, not lost; served in the next IDLE.
REQ-020 Minimum spacing between consecutive granted transactions SHALL be 2 cycles (ack cycle, IDLE cycle).
REQ-021 Datapath outputs in IDLE SHALL be driven from master 0 (don't-care, but deterministic).

Reset
REQ-022 While i_rst high at a clock edge: state IDLE, grant 0, last winner 1 (m0 wins first tie), timeout counter 0, o_timeout 0.
REQ-023 Reset asserted mid-BUSY SHALL abort the transaction: no ack issued, o_wb_mem_stb 0 the following cycle.
REQ-024 All outputs SHALL be 0 during and the cycle after reset, except mirrored datapath per REQ-021.

Configuration
REQ-025 Macro SERVILE_ARB_TIMEOUT_EN defined: counter increments each BUSY cycle without ack; when it equals TIMEOUT, arbiter SHALL ack the granted master with rdt 32'hFFFF_FFFF that cycle, drop o_wb_mem_stb, set o_timeout, return to IDLE, update last winner.
REQ-026 Counter SHALL clear on entering IDLE; o_timeout SHALL clear only on reset.
REQ-027 Macro undefined: no counter, no o_timeout port, BUSY waits indefinitely for ack.

Verification
REQ-028 After reset, m0 and m1 stb high same cycle -> m0 granted, mem_stb high cycle 1, m1 granted after m0 ack + 1 IDLE cycle.
REQ-029 m1 read adr 0x0000_0040, memory acks after 3 cycles with 0x1234_5678 -> o_wb_m1_ack one cycle, o_wb_m1_rdt 0x1234_5678, o_wb_m0_ack stays 0.
REQ-030 Both masters stb held continuously for 8 transactions -> grants alternate m0,m1,m0,...; each ack 2 cycles apart minimum.
REQ-031 m0 drops stb in BUSY before ack -> IDLE next cycle, no ack, next tie still grants m1 only if m1 last lost per pointer (pointer unchanged).
REQ-032 SERVILE_ARB_TIMEOUT_EN, TIMEOUT=4, memory never acks -> master ack with rdt 0xFFFF_FFFF on 4th BUSY wait cycle, o_timeout 1 until reset.
REQ-033 i_rst pulsed during m1 BUSY -> no m1 ack, state IDLE, next tie grants m0.
